// File: rtl/vga_pkg.sv
// Shared VGA constants, pattern-mode encoding and colour helpers used by the pattern generator.
package vga_pkg;

  localparam int ACTIVE_W = 640;
  localparam int ACTIVE_H = 480;
  localparam int COLOR_W  = 4;

  typedef enum logic [1:0] {
    MODE_BARS  = 2'd0,
    MODE_CHECK = 2'd1,
    MODE_BOX   = 2'd2,
    MODE_SOLID = 2'd3
  } mode_e;

  typedef struct packed {
    logic [COLOR_W-1:0] red;
    logic [COLOR_W-1:0] green;
    logic [COLOR_W-1:0] blue;
  } rgb_t;

  localparam rgb_t RGB_WHITE = rgb_t'(12'hFFF);
  localparam rgb_t RGB_BLUE  = rgb_t'(12'h008);
  localparam rgb_t RGB_GREY  = rgb_t'(12'h888);

  // Eight 80-pixel bars; each {R,G,B} code bit becomes a full-scale or zero channel.
  function automatic rgb_t barColor(input logic [9:0] ax);
    logic [9:0] idx;
    logic [2:0] code;
    idx = ax / 10'd80;
    case (idx)
      10'd0:   code = 3'b111;
      10'd1:   code = 3'b110;
      10'd2:   code = 3'b011;
      10'd3:   code = 3'b010;
      10'd4:   code = 3'b101;
      10'd5:   code = 3'b100;
      10'd6:   code = 3'b001;
      default: code = 3'b000;
    endcase
    return '{{COLOR_W{code[2]}}, {COLOR_W{code[1]}}, {COLOR_W{code[0]}}};
  endfunction

endpackage

// File: rtl/vga_box_mover.sv
// Bouncing box position: steps one pixel per axis at each frame start and reverses at the active-area edges.
module vga_box_mover
  import vga_pkg::*;
#(
  parameter int BOX_SIZE = 64
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       frameStart_i,
  output logic [9:0] boxX_o,
  output logic [9:0] boxY_o
);

  localparam logic [9:0] X_LIMIT = 10'(ACTIVE_W - BOX_SIZE);
  localparam logic [9:0] Y_LIMIT = 10'(ACTIVE_H - BOX_SIZE);

  logic [9:0] boxX_q, boxX_d, boxY_q, boxY_d;
  logic       dirX_q, dirX_d, dirY_q, dirY_d;

  // Direction 1 means increasing; the step that flips direction already moves away from the edge.
  function automatic logic [10:0] bounceStep(input logic [9:0] pos, input logic dir,
                                             input logic [9:0] limit);
    logic newDir;
    newDir = dir;
    if (dir && pos == limit) newDir = 1'b0;
    else if (!dir && pos == 10'd0) newDir = 1'b1;
    return {newDir, newDir ? pos + 10'd1 : pos - 10'd1};
  endfunction

  always_comb begin
    {dirX_d, boxX_d} = {dirX_q, boxX_q};
    {dirY_d, boxY_d} = {dirY_q, boxY_q};
    if (frameStart_i) begin
      {dirX_d, boxX_d} = bounceStep(boxX_q, dirX_q, X_LIMIT);
      {dirY_d, boxY_d} = bounceStep(boxY_q, dirY_q, Y_LIMIT);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      boxX_q <= '0;
      boxY_q <= '0;
      dirX_q <= 1'b1;
      dirY_q <= 1'b1;
    end else begin
      boxX_q <= boxX_d;
      boxY_q <= boxY_d;
      dirX_q <= dirX_d;
      dirY_q <= dirY_d;
    end
  end

  assign boxX_o = boxX_q;
  assign boxY_o = boxY_q;

endmodule

// File: rtl/vga_pattern_gen.sv
// Test-pattern generator with a 2-cycle aligned sync/RGB pipeline and frame-synchronous mode switching.
// Define PATTERN_GEN_BORDER_EN to draw a white 1-pixel border around the active area.
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int H_OFFSET = 144,
  parameter int V_OFFSET = 35,
  parameter int BOX_SIZE = 64
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_hsync,
  input  logic               i_vsync,
  input  logic               i_vid_on,
  input  logic [9:0]         i_pix_x,
  input  logic [9:0]         i_pix_y,
  input  logic [1:0]         i_mode_sel,
  input  logic               i_mode_load,
  output logic               o_hsync,
  output logic               o_vsync,
  output logic [COLOR_W-1:0] o_red,
  output logic [COLOR_W-1:0] o_green,
  output logic [COLOR_W-1:0] o_blue,
  output logic               o_frame_start
);

  logic [9:0] ax, ay, boxX, boxY;
  logic       frameStart, inBox;
  rgb_t       pixColor;
  mode_e      modeActive_q, modeActive_d, modePend_q, modePend_d;
  logic       vsyncPrev_q;
  logic       hsync1_q, vsync1_q, frameStart1_q, hsync2_q, vsync2_q, frameStart2_q;
  rgb_t       rgb1_q, rgb2_q;

  assign ax         = i_pix_x - 10'(H_OFFSET);
  assign ay         = i_pix_y - 10'(V_OFFSET);
  assign frameStart = i_vsync & ~vsyncPrev_q;
  assign inBox      = ({1'b0, ax} >= {1'b0, boxX}) && ({1'b0, ax} < {1'b0, boxX} + 11'(BOX_SIZE)) &&
                      ({1'b0, ay} >= {1'b0, boxY}) && ({1'b0, ay} < {1'b0, boxY} + 11'(BOX_SIZE));

  vga_box_mover #(
    .BOX_SIZE (BOX_SIZE)
  ) u_box_mover (
    .clk_i        (i_clk),
    .rst_i        (i_rst),
    .frameStart_i (frameStart),
    .boxX_o       (boxX),
    .boxY_o       (boxY)
  );

  // A strobe landing on the frame-start cycle goes straight through to the active mode.
  always_comb begin
    modePend_d   = modePend_q;
    modeActive_d = modeActive_q;
    if (i_mode_load) modePend_d = mode_e'(i_mode_sel);
    if (frameStart)  modeActive_d = modePend_d;
  end

  always_comb begin
    pixColor = '0;
    case (modeActive_q)
      MODE_BARS:  pixColor = barColor(ax);
      MODE_CHECK: pixColor = (ax[5] ^ ay[5]) ? RGB_WHITE : '0;
      MODE_BOX:   pixColor = inBox ? RGB_WHITE : RGB_BLUE;
      MODE_SOLID: pixColor = RGB_GREY;
      default:    pixColor = '0;
    endcase
`ifdef PATTERN_GEN_BORDER_EN
    if (ax == 10'd0 || ax == 10'(ACTIVE_W - 1) || ay == 10'd0 || ay == 10'(ACTIVE_H - 1))
      pixColor = RGB_WHITE;
`endif
    if (!i_vid_on) pixColor = '0;
  end

  // Colour is blanked before the first stage, so both stages carry sync and RGB in lockstep.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vsyncPrev_q   <= 1'b0;
      modePend_q    <= MODE_BARS;
      modeActive_q  <= MODE_BARS;
      hsync1_q      <= 1'b0;
      vsync1_q      <= 1'b0;
      frameStart1_q <= 1'b0;
      rgb1_q        <= '0;
      hsync2_q      <= 1'b0;
      vsync2_q      <= 1'b0;
      frameStart2_q <= 1'b0;
      rgb2_q        <= '0;
    end else begin
      vsyncPrev_q   <= i_vsync;
      modePend_q    <= modePend_d;
      modeActive_q  <= modeActive_d;
      hsync1_q      <= i_hsync;
      vsync1_q      <= i_vsync;
      frameStart1_q <= frameStart;
      rgb1_q        <= pixColor;
      hsync2_q      <= hsync1_q;
      vsync2_q      <= vsync1_q;
      frameStart2_q <= frameStart1_q;
      rgb2_q        <= rgb1_q;
    end
  end

  assign o_hsync       = hsync2_q;
  assign o_vsync       = vsync2_q;
  assign o_frame_start = frameStart2_q;
  assign o_red         = rgb2_q.red;
  assign o_green       = rgb2_q.green;
  assign o_blue        = rgb2_q.blue;

endmodule
